prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 200 ++++++++++++++++++++
 tb/tb_prog_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader -- loads a program image from a byte stream into word memory
// while holding the core in reset.
//
// Frame: word count N (2 bytes, little-endian), then 4N payload bytes,
// each word little-endian. With PROG_LOADER_CHECKSUM_EN defined, one
// extra byte follows the payload and must equal the XOR of all payload
// bytes; otherwise the load ends straight after the last word.
//
// Parameters
//   ADDR_BITS       program memory word-address width (capacity 2^ADDR_BITS)
//   TIMEOUT_CYCLES  max idle cycles between accepted bytes during a load
//
// Ports
//   clk, Reset      rising-edge clock, synchronous active-high reset
//   Start           one-cycle pulse, begins a load from IDLE/DONE/ERR
//   InValid/InData  byte stream in; InReady high while a load is running
//   MemWrEn         one-cycle write strobe per assembled word
//   MemAddr         word index of the write
//   MemWrData       assembled word
//   CoreReset       high except after a successful load
//   Busy            load in progress
//   Done / Error    sticky completion / abort flags (until next Start)
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
module prog_loader #(
    parameter int ADDR_BITS      = 9,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 InValid,
    input  logic [7:0]           InData,
    output logic                 InReady,
    output logic                 MemWrEn,
    output logic [ADDR_BITS-1:0] MemAddr,
    output logic [31:0]          MemWrData,
    output logic                 CoreReset,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Error
);

    localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    // Largest legal word count; 17 bits so 2^16 is representable.
    localparam logic [16:0]       CAPACITY  = 17'(1) << ADDR_BITS;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;
`endif

    state_t             state, stateNext;
    logic [15:0]        wordCount;
    logic [15:0]        wordIdx;
    logic [1:0]         byteCnt;
    logic [23:0]        asmWord;
    logic [IDLE_W-1:0]  idleCnt;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    logic               busyState;
    logic               accept;
    logic               startLoad;
    logic               idleExpired;
    logic [15:0]        newLen;
    logic               lenBad;
    logic               lastWord;
    logic               wordComplete;

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    // ---------------------------------------------------------------
    // Next state and state-decoded outputs
    // ---------------------------------------------------------------
    always_comb begin
        busyState = 1'b0;
        case (state)
            LEN_LO, LEN_HI, DATA: busyState = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            CHECK:                busyState = 1'b1;
`endif
            default:              busyState = 1'b0;
        endcase

        accept       = InValid && busyState;
        startLoad    = Start && ((state == IDLE) || (state == DONE) || (state == ERR));
        // An accepted byte in the expiring cycle wins over the timeout.
        idleExpired  = busyState && !accept && (idleCnt == IDLE_LAST);
        newLen       = {InData, wordCount[7:0]};
        lenBad       = (newLen == 16'd0) || ({1'b0, newLen} > CAPACITY);
        lastWord     = (wordIdx == wordCount - 16'd1);
        wordComplete = accept && (state == DATA) && (byteCnt == 2'd3);

        stateNext = state;
        case (state)
            IDLE, DONE, ERR: if (Start) stateNext = LEN_LO;
            LEN_LO: begin
                if (accept)           stateNext = LEN_HI;
                else if (idleExpired) stateNext = ERR;
            end
            LEN_HI: begin
                if (accept)           stateNext = lenBad ? ERR : DATA;
                else if (idleExpired) stateNext = ERR;
            end
            DATA: begin
                if (wordComplete && lastWord) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    stateNext = CHECK;
`else
                    stateNext = DONE;
`endif
                end else if (idleExpired) begin
                    stateNext = ERR;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept)           stateNext = (InData == csum) ? DONE : ERR;
                else if (idleExpired) stateNext = ERR;
            end
`endif
            default: stateNext = IDLE;
        endcase

        InReady   = busyState;
        Busy      = busyState;
        CoreReset = (state != DONE);
        Done      = (state == DONE);
        Error     = (state == ERR);
    end

    // ---------------------------------------------------------------
    // Datapath: length capture, word assembly, write port, idle timer
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (Reset) begin
            MemWrEn   <= 1'b0;
            MemAddr   <= '0;
            MemWrData <= '0;
            wordCount <= '0;
            wordIdx   <= '0;
            byteCnt   <= '0;
            asmWord   <= '0;
            idleCnt   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            MemWrEn <= 1'b0;
            // Counts only while waiting on the stream; zero outside a load.
            idleCnt <= (accept || !busyState) ? '0 : idleCnt + 1'b1;

            if (startLoad) begin
                wordIdx <= '0;
                byteCnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum    <= '0;
`endif
            end

            if (accept) begin
                case (state)
                    LEN_LO: wordCount[7:0]  <= InData;
                    LEN_HI: wordCount[15:8] <= InData;
                    DATA: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum    <= csum ^ InData;
`endif
                        byteCnt <= byteCnt + 2'd1;
                        case (byteCnt)
                            2'd0: asmWord[7:0]   <= InData;
                            2'd1: asmWord[15:8]  <= InData;
                            2'd2: asmWord[23:16] <= InData;
                            default: begin
                                // Fourth byte: the word is only written once
                                // complete, so a partial word never reaches memory.
                                MemWrEn   <= 1'b1;
                                MemAddr   <= wordIdx[ADDR_BITS-1:0];
                                MemWrData <= {InData, asmWord};
                                wordIdx   <= wordIdx + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. Frames are built from random word
// lists; the expected memory image is simply the word list itself, indexed
// by position. Works with or without PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;

    localparam int AB = 4;
    localparam int TO = 16;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          Reset, Start, InValid;
    logic [7:0]    InData;
    logic          InReady, MemWrEn, CoreReset, Busy, Done, Error;
    logic [AB-1:0] MemAddr;
    logic [31:0]   MemWrData;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_BITS(AB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .Reset(Reset), .Start(Start), .InValid(InValid), .InData(InData),
        .InReady(InReady), .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData),
        .CoreReset(CoreReset), .Busy(Busy), .Done(Done), .Error(Error)
    );

    int checks = 0;
    int errors = 0;

    logic [AB+31:0] gotQ[$];
    bit             gotDone[$];

    // Write monitor: records every strobe and the Done level alongside it.
    always @(negedge clk) begin
        if (MemWrEn) begin
            gotQ.push_back({MemAddr, MemWrData});
            gotDone.push_back(Done);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference framing: count LE, words LE, optional XOR byte.
    task automatic buildFrame(input logic [31:0] w[$], input bit badCk, output logic [7:0] f[$]);
        logic [7:0] x;
        int         n;
        x = 8'h00;
        n = w.size();
        f = {};
        f.push_back(n[7:0]);
        f.push_back(n[15:8]);
        foreach (w[i]) begin
            for (int b = 0; b < 4; b++) begin
                f.push_back(w[i][8*b +: 8]);
                x = x ^ w[i][8*b +: 8];
            end
        end
        if (CK) f.push_back(badCk ? (x ^ 8'h01) : x);
    endtask

    task automatic pulseStart();
        @(negedge clk); Start = 1'b1;
        @(negedge clk); Start = 1'b0;
    endtask

    // Drives bytes; optional random gaps (kept well below the timeout) and
    // stray Start pulses once the load is past the length field.
    task automatic sendBytes(input logic [7:0] f[$], input bit gaps, input bit pokeStart);
        int i, gapRun, guard;
        i = 0; gapRun = 0; guard = 0;
        while (i < f.size()) begin
            @(negedge clk);
            Start = pokeStart && (i >= 2) && ($urandom_range(0, 5) == 0);
            if (gaps && gapRun < 3 && $urandom_range(0, 2) == 0) begin
                InValid = 1'b0;
                InData  = 8'($urandom);
                gapRun++;
            end else begin
                gapRun  = 0;
                InValid = 1'b1;
                InData  = f[i];
                if (InReady) i++;
            end
            guard++;
            if (guard > 4000) begin
                chk("send_stall", i, f.size());
                break;
            end
        end
        @(negedge clk);
        InValid = 1'b0;
        Start   = 1'b0;
    endtask

    task automatic checkWrites(input string tag, input logic [31:0] w[$], input bit fin);
        repeat (2) @(negedge clk);
        chk({tag, ":nwr"}, gotQ.size(), w.size());
        for (int k = 0; k < w.size() && k < gotQ.size(); k++) begin
            chk($sformatf("%s:wr%0d", tag, k), gotQ[k], {AB'(k), w[k]});
            chk($sformatf("%s:done%0d", tag, k), gotDone[k], !CK && fin && (k == w.size() - 1));
        end
        gotQ.delete();
        gotDone.delete();
    endtask

    task automatic checkFinal(input string tag, input bit expDone, input bit expErr);
        chk({tag, ":done"}, Done, expDone);
        chk({tag, ":err"},  Error, expErr);
        chk({tag, ":crst"}, CoreReset, !expDone);
        chk({tag, ":busy"}, Busy, 1'b0);
    endtask

    task automatic checkResetVals(input string tag);
        chk({tag, ":rdy"},  InReady, 1'b0);
        chk({tag, ":wen"},  MemWrEn, 1'b0);
        chk({tag, ":addr"}, MemAddr, '0);
        chk({tag, ":data"}, MemWrData, 32'h0);
        chk({tag, ":busy"}, Busy, 1'b0);
        chk({tag, ":done"}, Done, 1'b0);
        chk({tag, ":err"},  Error, 1'b0);
        chk({tag, ":crst"}, CoreReset, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w[$];
        logic [31:0] none[$];
        logic [7:0]  f[$];
        logic [7:0]  g[$];
        int          n;
        bit          bad;

        Reset = 1'b1; Start = 1'b0; InValid = 1'b0; InData = 8'h00;
        repeat (3) @(negedge clk);
        checkResetVals("rst");
        Reset = 1'b0;
        @(negedge clk);

        // Two-word program, back-to-back bytes.
        w = '{32'h00000013, 32'h00100093};
        buildFrame(w, 1'b0, f);
        pulseStart();
        sendBytes(f, 1'b0, 1'b0);
        checkWrites("basic", w, 1'b1);
        checkFinal("basic", 1'b1, 1'b0);

        // Restart from DONE clears Done; zero length aborts.
        pulseStart();
        chk("restart:done", Done, 1'b0);
        chk("restart:busy", Busy, 1'b1);
        chk("restart:crst", CoreReset, 1'b1);
        f = '{8'h00, 8'h00};
        sendBytes(f, 1'b0, 1'b0);
        checkWrites("n0", none, 1'b0);
        checkFinal("n0", 1'b0, 1'b1);

        // One word beyond capacity aborts.
        pulseStart();
        f = '{8'(2**AB + 1), 8'h00};
        sendBytes(f, 1'b0, 1'b0);
        checkWrites("ncap", none, 1'b0);
        checkFinal("ncap", 1'b0, 1'b1);

        // Exactly capacity is legal.
        w = {};
        for (int k = 0; k < 2**AB; k++) w.push_back($urandom);
        buildFrame(w, 1'b0, f);
        pulseStart();
        sendBytes(f, 1'b1, 1'b0);
        checkWrites("full", w, 1'b1);
        checkFinal("full", 1'b1, 1'b0);

        // Timeout waiting for the length.
        pulseStart();
        repeat (TO - 1) @(negedge clk);
        chk("tolen:busy", Busy, 1'b1);
        @(negedge clk);
        chk("tolen:err", Error, 1'b1);

        // Timeout mid-word: partial word never written.
        w = '{$urandom};
        buildFrame(w, 1'b0, f);
        g = f[0:4];
        pulseStart();
        sendBytes(g, 1'b0, 1'b0);
        repeat (TO - 1) @(negedge clk);
        chk("todat:busy", Busy, 1'b1);
        chk("todat:err0", Error, 1'b0);
        @(negedge clk);
        chk("todat:err1", Error, 1'b1);
        checkWrites("todat", none, 1'b0);

        // Byte arriving in the expiring cycle is accepted.
        pulseStart();
        sendBytes(g, 1'b0, 1'b0);
        repeat (TO - 1) @(negedge clk);
        InValid = 1'b1;
        InData  = f[5];
        chk("race:rdy", InReady, 1'b1);
        @(negedge clk);
        InValid = 1'b0;
        if (CK) begin
            g = f[6:6];
            sendBytes(g, 1'b0, 1'b0);
        end
        checkWrites("race", w, 1'b1);
        checkFinal("race", 1'b1, 1'b0);

        // Reset after 6 bytes of a 4-word load.
        w = {};
        for (int k = 0; k < 4; k++) w.push_back($urandom);
        buildFrame(w, 1'b0, f);
        g = f[0:5];
        pulseStart();
        sendBytes(g, 1'b0, 1'b0);
        @(negedge clk);
        chk("midrst:pre", gotQ.size(), 1);
        gotQ.delete();
        gotDone.delete();
        Reset = 1'b1;
        @(negedge clk);
        InValid = 1'b1;
        InData  = f[6];
        @(negedge clk);
        Reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            InData = 8'($urandom);
        end
        checkResetVals("midrst");
        InValid = 1'b0;
        chk("midrst:nwr", gotQ.size(), 0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Check byte match / mismatch for word 0x11223344.
        w = '{32'h11223344};
        f = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
        pulseStart();
        sendBytes(f, 1'b0, 1'b0);
        checkWrites("ckok", w, 1'b1);
        checkFinal("ckok", 1'b1, 1'b0);
        f[6] = 8'h45;
        pulseStart();
        sendBytes(f, 1'b0, 1'b0);
        checkWrites("ckbad", w, 1'b0);
        checkFinal("ckbad", 1'b0, 1'b1);
`endif

        // Random programs, gapped stream, stray Start pulses mid-load.
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 2**AB);
            w = {};
            for (int k = 0; k < n; k++) w.push_back($urandom);
            bad = CK && ($urandom_range(0, 2) == 0);
            buildFrame(w, bad, f);
            pulseStart();
            sendBytes(f, 1'b1, 1'b1);
            checkWrites($sformatf("rnd%0d", t), w, !bad);
            checkFinal($sformatf("rnd%0d", t), !bad, bad);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
